// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared funct3 codes, FSM states and access sizes for the data memory LSU
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {S_CLEAR, S_READY} dmem_state_t;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} access_size_t;

    // funct3[1:0] selects the width for loads and stores alike; 2'b11 is rejected as illegal upstream
    function automatic access_size_t f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering for stores, shift/extend for loads, alignment check
module dmem_lane_align
    import dmem_pkg::*;
(
    input  access_size_t req_size_i,
    input  logic [1:0]   req_lane_i,
    input  logic [31:0]  req_wdata_i,
    output logic [3:0]   st_be_o,
    output logic [31:0]  st_data_o,
    output logic         misaligned_o,
    input  logic [31:0]  ld_word_i,
    input  logic [1:0]   ld_lane_i,
    input  access_size_t ld_size_i,
    input  logic         ld_unsigned_i,
    output logic [31:0]  ld_data_o
);

    logic [31:0] ld_shifted;

    always_comb begin
        st_be_o      = 4'b1111;
        st_data_o    = req_wdata_i;
        misaligned_o = 1'b0;
        case (req_size_i)
            SZ_B: begin
                st_be_o   = 4'b0001 << req_lane_i;
                st_data_o = {4{req_wdata_i[7:0]}};
            end
            SZ_H: begin
                st_be_o      = 4'b0011 << req_lane_i;
                st_data_o    = {2{req_wdata_i[15:0]}};
                misaligned_o = req_lane_i[0];
            end
            default: begin
                misaligned_o = |req_lane_i;
            end
        endcase
    end

    assign ld_shifted = ld_word_i >> {ld_lane_i, 3'b000};

    always_comb begin
        ld_data_o = ld_shifted;
        case (ld_size_i)
            SZ_B: ld_data_o = ld_unsigned_i ? {24'b0, ld_shifted[7:0]}
                                            : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            SZ_H: ld_data_o = ld_unsigned_i ? {16'b0, ld_shifted[15:0]}
                                            : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            default: ld_data_o = ld_shifted;
        endcase
    end

endmodule

// File: rtl/data_memory_lsu.sv
// rtl/data_memory_lsu.sv - RV32I load/store data memory with fault detection and post-reset clear
module data_memory_lsu
    import dmem_pkg::*;
#(
    parameter int DEPTH          = 1024,
    parameter int ADDR_WIDTH     = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_fault,
    output logic                  busy
);

    localparam int IW = $clog2(DEPTH);

    dmem_state_t   state_q, state_d;
    logic [IW-1:0] clr_idx_q, clr_idx_d;
    logic [31:0]   mem [DEPTH];

    logic [IW-1:0] idx;
    logic [1:0]    lane;
    access_size_t  size;
    logic          illegal, misaligned, out_of_range, fault, accept, do_store;
    logic [3:0]    st_be;
    logic [31:0]   st_data, ld_data;

    logic          rsp_valid_q, rsp_fault_q, rsp_load_q;
    logic [31:0]   rd_word_q;
    logic [1:0]    ld_lane_q;
    access_size_t  ld_size_q;
    logic          ld_unsigned_q;

    assign idx  = req_addr[2+IW-1:2];
    assign lane = req_addr[1:0];
    assign size = f3_size(req_funct3);

    assign illegal      = req_write ? (req_funct3 >= 3'b011)
                                    : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
    assign out_of_range = |(req_addr >> (2 + IW));
    assign fault        = illegal | misaligned | out_of_range;

    assign req_ready = (state_q == S_READY) && !rst;
    assign accept    = req_valid && req_ready;
    assign do_store  = accept && req_write && !fault;
    assign busy      = (state_q == S_CLEAR);

    dmem_lane_align u_align (
        .req_size_i    (size),
        .req_lane_i    (lane),
        .req_wdata_i   (req_wdata),
        .st_be_o       (st_be),
        .st_data_o     (st_data),
        .misaligned_o  (misaligned),
        .ld_word_i     (rd_word_q),
        .ld_lane_i     (ld_lane_q),
        .ld_size_i     (ld_size_q),
        .ld_unsigned_i (ld_unsigned_q),
        .ld_data_o     (ld_data)
    );

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == S_CLEAR) begin
            clr_idx_d = clr_idx_q + IW'(1);
            if (clr_idx_q == IW'(DEPTH - 1)) state_d = S_READY;
        end
        if (rst) begin
            state_d   = CLEAR_ON_RESET ? S_CLEAR : S_READY;
            clr_idx_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        clr_idx_q <= clr_idx_d;
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_load_q  <= 1'b0;
        end else begin
            rsp_valid_q <= accept;
            rsp_fault_q <= accept && fault;
            rsp_load_q  <= accept && !req_write && !fault;
        end
        // Load context is captured only on accept; rsp_load_q gates its use
        if (accept) begin
            rd_word_q     <= mem[idx];
            ld_lane_q     <= lane;
            ld_size_q     <= size;
            ld_unsigned_q <= req_funct3[2];
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem[clr_idx_q] <= '0;
        end else if (do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) mem[idx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_fault = rsp_fault_q;
    assign rsp_rdata = rsp_load_q ? ld_data : 32'h0;

endmodule

// File: tb/tb_data_memory_lsu.sv
// tb/tb_data_memory_lsu.sv - scoreboard bench for data_memory_lsu with DEPTH=16
module tb_data_memory_lsu;

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] er;
        logic        ef;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        busy;

    int   n_chk = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    data_memory_lsu #(.DEPTH(16), .ADDR_WIDTH(32), .CLEAR_ON_RESET(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic req_t mk(logic w, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                                logic [31:0] er, logic ef);
        req_t r;
        r.w = w; r.f3 = f3; r.a = a; r.wd = wd; r.er = er; r.ef = ef;
        return r;
    endfunction

    task automatic drive(input req_t r);
        exp_t e;
        req_valid  = 1'b1;
        req_write  = r.w;
        req_funct3 = r.f3;
        req_addr   = r.a;
        req_wdata  = r.wd;
        e.rdata = r.er;
        e.fault = r.ef;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        idle();
        step();
        step();
        n_chk += 5;
        if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
        if (rsp_fault !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_fault got=%b exp=0", rsp_fault); end
        if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy got=%b exp=1", busy); end
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && req_ready === 1'b0 && n < 100) begin n++; step(); end
        n_chk += 2;
        if (n != 16) begin n_bad++; $display("FAIL reset_clear_cycles got=%0d exp=16", n); end
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_ready_after got ready=%b busy=%b exp 1/0", req_ready, busy);
        end
    endtask

    task automatic test_clear();
        req_t t[$];
        exp_t e;
        int   n;
        exp_q.delete();
        for (int i = 0; i < 16; i++) t.push_back(mk(1, 3'b010, 32'(i*4), 32'hA5A50000 | 32'(i), 0, 0));
        foreach (t[i]) begin
            drive(t[i]);
            step();
            n_chk++;
            if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
                n_bad++; $display("FAIL clear_fill[%0d] rsp_valid got=%b exp=1", i, rsp_valid);
            end else begin
                e = exp_q.pop_front();
                if (rsp_rdata !== e.rdata || rsp_fault !== e.fault) begin
                    n_bad++; $display("FAIL clear_fill[%0d] got=%h/%b exp=%h/%b", i, rsp_rdata, rsp_fault, e.rdata, e.fault);
                end
            end
        end
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && req_ready === 1'b0 && n < 100) begin n++; step(); end
        n_chk++;
        if (n != 16) begin n_bad++; $display("FAIL clear_cycles got=%0d exp=16", n); end
        t.delete();
        exp_q.delete();
        for (int i = 0; i < 16; i++) t.push_back(mk(0, 3'b010, 32'(i*4), 0, 32'h0, 0));
        foreach (t[i]) begin
            drive(t[i]);
            step();
            n_chk++;
            if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
                n_bad++; $display("FAIL clear_read[%0d] rsp_valid got=%b exp=1", i, rsp_valid);
            end else begin
                e = exp_q.pop_front();
                if (rsp_rdata !== e.rdata || rsp_fault !== e.fault) begin
                    n_bad++; $display("FAIL clear_read[%0d] got=%h/%b exp=%h/%b", i, rsp_rdata, rsp_fault, e.rdata, e.fault);
                end
            end
        end
        idle();
        step();
    endtask

    task automatic test_sizes();
        req_t t[$];
        exp_t e;
        exp_q.delete();
        t.push_back(mk(1, 3'b010, 32'h10, 32'h80FF7F01, 32'h0, 0));
        t.push_back(mk(0, 3'b000, 32'h11, 0, 32'h0000007F, 0));
        t.push_back(mk(0, 3'b000, 32'h13, 0, 32'hFFFFFF80, 0));
        t.push_back(mk(0, 3'b100, 32'h12, 0, 32'h000000FF, 0));
        t.push_back(mk(0, 3'b001, 32'h12, 0, 32'hFFFF80FF, 0));
        t.push_back(mk(0, 3'b101, 32'h10, 0, 32'h00007F01, 0));
        t.push_back(mk(0, 3'b101, 32'h12, 0, 32'h000080FF, 0));
        t.push_back(mk(1, 3'b010, 32'h20, 32'h00000000, 32'h0, 0));
        t.push_back(mk(1, 3'b000, 32'h22, 32'h000000AB, 32'h0, 0));
        t.push_back(mk(1, 3'b001, 32'h20, 32'h0000BEEF, 32'h0, 0));
        t.push_back(mk(0, 3'b010, 32'h20, 0, 32'h00ABBEEF, 0));
        foreach (t[i]) begin
            drive(t[i]);
            step();
            n_chk++;
            if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
                n_bad++; $display("FAIL sizes[%0d] rsp_valid got=%b exp=1", i, rsp_valid);
            end else begin
                e = exp_q.pop_front();
                if (rsp_rdata !== e.rdata || rsp_fault !== e.fault) begin
                    n_bad++; $display("FAIL sizes[%0d] got=%h/%b exp=%h/%b", i, rsp_rdata, rsp_fault, e.rdata, e.fault);
                end
            end
        end
        idle();
        step();
    endtask

    task automatic test_faults();
        req_t t[$];
        exp_t e;
        exp_q.delete();
        t.push_back(mk(1, 3'b010, 32'h24, 32'h11223344, 32'h0, 0));
        t.push_back(mk(0, 3'b010, 32'h21, 0, 32'h0, 1));
        t.push_back(mk(0, 3'b001, 32'h23, 0, 32'h0, 1));
        t.push_back(mk(1, 3'b011, 32'h24, 32'hDEADBEEF, 32'h0, 1));
        t.push_back(mk(0, 3'b010, 32'h40, 0, 32'h0, 1));
        t.push_back(mk(0, 3'b011, 32'h24, 0, 32'h0, 1));
        t.push_back(mk(0, 3'b110, 32'h24, 0, 32'h0, 1));
        t.push_back(mk(1, 3'b000, 32'h40, 32'h000000EE, 32'h0, 1));
        t.push_back(mk(1, 3'b010, 32'h22, 32'hCAFECAFE, 32'h0, 1));
        t.push_back(mk(0, 3'b010, 32'h24, 0, 32'h11223344, 0));
        t.push_back(mk(0, 3'b010, 32'h20, 0, 32'h00ABBEEF, 0));
        t.push_back(mk(0, 3'b010, 32'h00, 0, 32'h00000000, 0));
        foreach (t[i]) begin
            drive(t[i]);
            step();
            n_chk++;
            if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
                n_bad++; $display("FAIL faults[%0d] rsp_valid got=%b exp=1", i, rsp_valid);
            end else begin
                e = exp_q.pop_front();
                if (rsp_rdata !== e.rdata || rsp_fault !== e.fault) begin
                    n_bad++; $display("FAIL faults[%0d] got=%h/%b exp=%h/%b", i, rsp_rdata, rsp_fault, e.rdata, e.fault);
                end
            end
        end
        idle();
        step();
    endtask

    task automatic test_back_to_back();
        req_t t[$];
        exp_t e;
        exp_q.delete();
        t.push_back(mk(1, 3'b010, 32'h08, 32'h12345678, 32'h0, 0));
        t.push_back(mk(0, 3'b010, 32'h08, 0, 32'h12345678, 0));
        t.push_back(mk(0, 3'b010, 32'h08, 0, 32'h12345678, 0));
        foreach (t[i]) begin
            drive(t[i]);
            step();
            n_chk++;
            if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
                n_bad++; $display("FAIL b2b[%0d] rsp_valid got=%b exp=1", i, rsp_valid);
            end else begin
                e = exp_q.pop_front();
                if (rsp_rdata !== e.rdata || rsp_fault !== e.fault) begin
                    n_bad++; $display("FAIL b2b[%0d] got=%h/%b exp=%h/%b", i, rsp_rdata, rsp_fault, e.rdata, e.fault);
                end
            end
        end
        idle();
        step();
        n_chk++;
        if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle rsp_valid got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_reset_mid_clear();
        exp_t e;
        int   n;
        logic rdy_seen;
        exp_q.delete();
        drive(mk(0, 3'b010, 32'h08, 0, 32'h12345678, 0));
        step();
        n_chk++;
        if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
            n_bad++; $display("FAIL mid_pre rsp_valid got=%b exp=1", rsp_valid);
        end else begin
            e = exp_q.pop_front();
            if (rsp_rdata !== e.rdata) begin n_bad++; $display("FAIL mid_pre rdata got=%h exp=%h", rsp_rdata, e.rdata); end
        end
        rst = 1'b1;
        step();
        n_chk++;
        if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_drop rsp_valid got=%b exp=0", rsp_valid); end
        step();
        rst = 1'b0;
        rdy_seen = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (req_ready !== 1'b0 || busy !== 1'b1 || rsp_valid !== 1'b0) rdy_seen = 1'b1;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            if (req_ready !== 1'b0 || rsp_valid !== 1'b0) rdy_seen = 1'b1;
            n++;
            step();
        end
        n_chk += 2;
        if (rdy_seen) begin n_bad++; $display("FAIL mid_hold ready/rsp asserted during clear"); end
        if (n != 16) begin n_bad++; $display("FAIL mid_clear_cycles got=%0d exp=16", n); end
        e.rdata = 32'h0;
        e.fault = 1'b0;
        exp_q.push_back(e);
        step();
        n_chk++;
        if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
            n_bad++; $display("FAIL mid_held_req rsp_valid got=%b exp=1", rsp_valid);
        end else begin
            e = exp_q.pop_front();
            if (rsp_rdata !== e.rdata || rsp_fault !== e.fault) begin
                n_bad++; $display("FAIL mid_held_req got=%h/%b exp=%h/%b", rsp_rdata, rsp_fault, e.rdata, e.fault);
            end
        end
        idle();
        step();
    endtask

    initial begin
        test_reset();
        test_clear();
        test_sizes();
        test_faults();
        test_back_to_back();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/data_memory_lsu.md
Name: data_memory_lsu

Overview:
Parametrised successor to the word-addressed data memory, holding RV32I load/store semantics in the memory block itself. It accepts one request per cycle over a valid/ready handshake and decodes funct3 into byte, half or word accesses with sign or zero extension. It detects misaligned, out-of-range and illegal accesses, and zeroes its array with a clear sequencer after reset. It sits between the core's execute/memory stage and the register-file writeback mux.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two, minimum 4.
ADDR_WIDTH, 32, width of the byte address.
CLEAR_ON_RESET, 1, when 1 the array is zeroed after reset; when 0 the block is ready immediately.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request this cycle.
req_write  in  1  1 = store, 0 = load.
req_funct3  in  3  RV32I funct3: loads LB=000 LH=001 LW=010 LBU=100 LHU=101; stores SB=000 SH=001 SW=010.
req_addr  in  ADDR_WIDTH  byte address.
req_wdata  in  32  store data; the low bits are used for SB/SH.
rsp_valid  out  1  response valid for exactly one cycle.
rsp_rdata  out  32  extended load data; 0 for stores and faults.
rsp_fault  out  1  access rejected.
busy  out  1  clear sequencer is active.

Behaviour:
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_fault=0, req_ready=0. busy=1 if CLEAR_ON_RESET, else 0.
- FSM states are CLEAR and READY. rst forces CLEAR with clr_idx=0 when CLEAR_ON_RESET=1, otherwise READY.
- In CLEAR, one word per cycle is written: mem[clr_idx]=0, then clr_idx increments. After the word at DEPTH-1 is written, the next state is READY. The clear takes DEPTH cycles.
- rst asserted mid-clear restarts the clear at index 0. rst asserted while a response is pending drops that response: rsp_valid=0 on the next cycle.
- req_ready = (state==READY) and not rst. A request is accepted when req_valid and req_ready are both high at a rising edge. Back-to-back accepts every cycle are supported.
- Latency: the response appears exactly 1 cycle after accept. There is no response back-pressure.
- Word index is req_addr[2+$clog2(DEPTH)-1:2]; lane is req_addr[1:0].
- Fault conditions, checked in this priority:
  - illegal funct3: loads 011/110/111; stores >=011.
  - misaligned: half access with lane[0]=1, or word access with lane!=0.
  - out of range: any set bit of req_addr above the index bits.
- On a fault: no array write, rsp_fault=1, rsp_rdata=0.
- Store byte enable: SB is 4'b0001<<lane and SH is 4'b0011<<lane. Store data is replicated: the byte into all 4 lanes, the half into both halves. SW uses 4'b1111.
- The write commits on the accept edge.
- Load path: the word read is registered at the accept edge, shifted right by 8*lane, then truncated and extended per funct3. LB/LH sign-extend; LBU/LHU zero-extend.
- Read-after-write: a load accepted the cycle after a store to the same word returns the stored data.
- A store's response has rsp_valid=1, rsp_fault=0, rsp_rdata=0.
- Requests present during CLEAR are not accepted and are not lost. The requester holds req_valid.

Decomposition:
- Package dmem_pkg holds:
  - the funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - typedef enum logic {S_CLEAR, S_READY} dmem_state_t;
  - typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} access_size_t.
- One sub-module, dmem_lane_align, is combinational and contains:
  - store byte-enable and replication generation;
  - load shift and extension;
  - misalignment check.
- The top module keeps the array, the FSM, the handshake and the response registers.

Test Plan:
- Clear: DEPTH=16 with prior garbage writes, pulse rst. Required: busy=1 and req_ready=0 for 16 cycles, then LW of addresses 0x0..0x3C returns 0x00000000 each, with no fault.
- Byte/half/word: SW 0x80FF7F01 to 0x10. Then:
  - LB 0x11 returns 0x0000007F.
  - LB 0x13 returns 0xFFFFFF80.
  - LBU 0x12 returns 0x000000FF.
  - LH 0x12 returns 0xFFFF80FF.
  - LHU 0x10 returns 0x00007F01.
- Partial stores: SW 0x00000000 to 0x20, SB 0xAB to 0x22, SH 0xBEEF to 0x20. Required: LW 0x20 returns 0x00ABBEEF.
- Faults, each with rsp_fault=1, rsp_rdata=0 and the memory word unchanged:
  - LW 0x21;
  - LH 0x23;
  - SW 0x24 with funct3=011;
  - LW 0x40 (DEPTH=16).
- Back-to-back and RAW: SW 0x12345678 to 0x8 on cycle N, LW 0x8 on N+1, LW 0x8 on N+2. Required: rsp_valid on N+1/N+2/N+3, and both loads return 0x12345678.
- Reset mid-clear: assert rst at clear cycle 7. Required: busy stays high for a further 16 cycles after rst deasserts, req_ready=0 throughout, and a pending rsp_valid is dropped.
